// File: rtl/load_return_if.sv
// Execute-side, read-target and writeback signals of load_return_unit.
// The master modport is the surrounding pipeline; the slave modport is the unit.
interface load_return_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned N_TGT  = 2
);
   localparam int unsigned DATA_W = 32;

   logic                      issue;
   logic [4:0]                uop;
   logic [ADDR_W-1:0]         addr;
   logic [1:0]                size;
   logic                      sign_ext;
   logic [DATA_W-1:0]         alu;
   logic [N_TGT-1:0]          tgt_req;
   logic [ADDR_W-1:0]         tgt_addr;
   logic [N_TGT-1:0]          tgt_ack;
   logic [DATA_W*N_TGT-1:0]   tgt_rdata;
   logic                      stall;
   logic                      wb_valid;
   logic [DATA_W-1:0]         wb_data;
   logic                      load_err;

   modport master (
      output issue, uop, addr, size, sign_ext, alu, tgt_ack, tgt_rdata,
      input  tgt_req, tgt_addr, stall, wb_valid, wb_data, load_err
   );

   modport slave (
      input  issue, uop, addr, size, sign_ext, alu, tgt_ack, tgt_rdata,
      output tgt_req, tgt_addr, stall, wb_valid, wb_data, load_err
   );
endinterface

// File: rtl/load_return_unit.sv
// Writeback-source unit: forwards ALU results, or runs req/ack loads from address-mapped targets.
// Define LOAD_RETURN_TIMEOUT_EN to abort loads that wait TIMEOUT cycles without an ack.
module load_return_unit #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned N_TGT     = 2,
   parameter int unsigned TGT_SHIFT = 5,
   parameter logic [4:0]  UOP_LDR   = 5'd10,
   parameter int unsigned TIMEOUT   = 15
) (
   input logic          clk,
   input logic          rst,
   load_return_if.slave bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = ADDR_W - TGT_SHIFT;
   localparam int unsigned TIW    = (N_TGT > 1) ? $clog2(N_TGT) : 1;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("load_return_unit: TIMEOUT must be >= 1");
   end

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [N_TGT-1:0]  req_q, req_d;
   logic [ADDR_W-1:0] taddr_q, taddr_d;
   logic [TIW-1:0]    idx_q, idx_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic              wb_valid_q, wb_valid_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              err_q, err_d;

`ifdef LOAD_RETURN_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cnt_tc;
   assign cnt_tc = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   // Issue-side decode of the presented uOP
   logic [IDX_W-1:0]  tgt_field;
   logic [TIW-1:0]    tgt_idx;
   logic              is_load;
   logic              mapped;
   logic              aligned;
   logic              accept;

   assign tgt_field = bus.addr[ADDR_W-1:TGT_SHIFT];
   assign tgt_idx   = TIW'(tgt_field);
   assign is_load   = (bus.uop == UOP_LDR);
   assign mapped    = (tgt_field < IDX_W'(N_TGT));
   assign accept    = bus.issue & is_load & mapped & aligned;

   always_comb begin
      aligned = (bus.addr[1:0] == 2'b00);
      case (bus.size)
         2'b10:   aligned = 1'b1;
         2'b01:   aligned = ~bus.addr[0];
         default: ;
      endcase
   end

   // Return path from the target being waited on
   logic              ack_hit;
   logic [DATA_W-1:0] rdata_sel;

   assign ack_hit   = bus.tgt_ack[idx_q];
   assign rdata_sel = bus.tgt_rdata[idx_q*DATA_W +: DATA_W];

   function automatic logic [DATA_W-1:0] extract(
      input logic [DATA_W-1:0] word,
      input logic [1:0]        lane,
      input logic [1:0]        sz,
      input logic              sx
   );
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*lane +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b10:   extract = {{24{sx & b[7]}}, b};
         2'b01:   extract = {{16{sx & h[15]}}, h};
         default: extract = word;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      taddr_d    = taddr_q;
      idx_d      = idx_q;
      size_d     = size_q;
      sext_d     = sext_q;
      wb_valid_d = 1'b0;
      wb_data_d  = wb_data_q;
      err_d      = 1'b0;
`ifdef LOAD_RETURN_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.issue) begin
               if (!is_load) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = bus.alu;
               end else if (!accept) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = '0;
                  err_d      = 1'b1;
               end else begin
                  state_d = WAIT;
                  req_d   = N_TGT'(1) << tgt_idx;
                  idx_d   = tgt_idx;
                  taddr_d = bus.addr;
                  size_d  = bus.size;
                  sext_d  = bus.sign_ext;
`ifdef LOAD_RETURN_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         WAIT: begin
            // An ack in the terminal-count cycle still completes the load
            if (ack_hit) begin
               state_d    = IDLE;
               req_d      = '0;
               wb_valid_d = 1'b1;
               wb_data_d  = extract(rdata_sel, taddr_q[1:0], size_q, sext_q);
            end
`ifdef LOAD_RETURN_TIMEOUT_EN
            else if (cnt_tc) begin
               state_d    = IDLE;
               req_d      = '0;
               wb_valid_d = 1'b1;
               wb_data_d  = '0;
               err_d      = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         req_q      <= '0;
         taddr_q    <= '0;
         idx_q      <= '0;
         size_q     <= '0;
         sext_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         err_q      <= 1'b0;
`ifdef LOAD_RETURN_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         taddr_q    <= taddr_d;
         idx_q      <= idx_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         err_q      <= err_d;
`ifdef LOAD_RETURN_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign bus.tgt_req  = req_q;
   assign bus.tgt_addr = taddr_q;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.load_err = err_q;

   // Stall covers the accept cycle too, so upstream holds while the load is outstanding
   assign bus.stall = ~rst & ((state_q == WAIT) | ((state_q == IDLE) & accept));
endmodule
